// File: rtl/stack_op_sequencer_if.sv
// ============================================================================
// Module      : stack_op_sequencer_if
// Description : Decode-side inputs and memory/PC control outputs of the stack
//               operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stack_op_sequencer_if;
    logic [4:0] opcode;
    logic       op_valid;
    logic       int_req;
    logic       ldm;
    logic       load_use;

    logic       mem_we;
    logic       mem_re;
    logic       stack;
    logic [1:0] mem_data_sel;
    logic [1:0] pop_sel;
    logic [1:0] pc_sel;
    logic       freeze_pc;
    logic       freeze_cu;
    logic       busy;
    logic       int_ack;

    modport master (
        output opcode, op_valid, int_req, ldm, load_use,
        input  mem_we, mem_re, stack, mem_data_sel, pop_sel, pc_sel,
               freeze_pc, freeze_cu, busy, int_ack
    );

    modport slave (
        input  opcode, op_valid, int_req, ldm, load_use,
        output mem_we, mem_re, stack, mem_data_sel, pop_sel, pc_sel,
               freeze_pc, freeze_cu, busy, int_ack
    );
endinterface

`default_nettype wire

// File: rtl/stack_op_sequencer.sv
// ============================================================================
// Module      : stack_op_sequencer
// Description : Multi-cycle CALL/RET/RTI and interrupt stack push/pop sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_op_sequencer (
    input  wire logic            clk,
    input  wire logic            rst,
    stack_op_sequencer_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INT_WAIT  = 4'd1,
        S_INT_WAIT2 = 4'd2,
        S_PUSH_PC1  = 4'd3,
        S_PUSH_PC2  = 4'd4,
        S_PUSH_CCR  = 4'd5,
        S_POP_CCR   = 4'd6,
        S_POP_PC2   = 4'd7,
        S_POP_PC1   = 4'd8,
        S_LOAD_PC   = 4'd9
    } state_t;

    localparam logic [4:0] c_OP_CALL  = 5'b11000;
    localparam logic [4:0] c_OP_RET   = 5'b11001;
    localparam logic [4:0] c_OP_RTI   = 5'b11010;

    localparam logic [1:0] c_SRC_CALL = 2'b01;
    localparam logic [1:0] c_SRC_POP  = 2'b10;
    localparam logic [1:0] c_SRC_INT  = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] src_q, src_d;
    logic       int_req_d_q;
    logic       int_pending_q, int_pending_d;

    logic       w_is_call, w_is_ret, w_is_rti;
    logic       w_int_edge, w_int_clear;

    logic       w_mem_we, w_mem_re, w_stack;
    logic [1:0] w_mem_data_sel, w_pop_sel, w_pc_sel;
    logic       w_freeze_pc, w_freeze_cu, w_busy, w_int_ack;

    assign w_is_call  = bus.op_valid && (bus.opcode == c_OP_CALL);
    assign w_is_ret   = bus.op_valid && (bus.opcode == c_OP_RET);
    assign w_is_rti   = bus.op_valid && (bus.opcode == c_OP_RTI);
    assign w_int_edge = bus.int_req && !int_req_d_q;

    // A fresh edge arriving as the pending flag is consumed must not be lost.
    assign int_pending_d = w_int_edge || (int_pending_q && !w_int_clear);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            src_q         <= 2'b00;
            int_req_d_q   <= 1'b0;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            int_req_d_q   <= bus.int_req;
            int_pending_q <= int_pending_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        w_int_clear    = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_re       = 1'b0;
        w_stack        = 1'b0;
        w_mem_data_sel = 2'b00;
        w_pop_sel      = 2'b00;
        w_pc_sel       = 2'b00;
        w_freeze_pc    = 1'b0;
        w_freeze_cu    = 1'b0;
        w_busy         = 1'b0;
        w_int_ack      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Decoded stack instructions take priority over a pending interrupt.
                if (w_is_call) begin
                    state_d = S_PUSH_PC1;
                    src_d   = c_SRC_CALL;
                end else if (w_is_ret) begin
                    state_d = S_POP_PC2;
                    src_d   = c_SRC_POP;
                end else if (w_is_rti) begin
                    state_d = S_POP_CCR;
                    src_d   = c_SRC_POP;
                end else if (int_pending_q) begin
                    state_d     = S_INT_WAIT;
                    src_d       = c_SRC_INT;
                    w_int_clear = 1'b1;
                    w_int_ack   = 1'b1;
                end
            end
            S_INT_WAIT: begin
                {w_freeze_pc, w_freeze_cu, w_busy} = 3'b111;
                state_d = (bus.ldm || bus.load_use) ? S_INT_WAIT2 : S_PUSH_PC1;
            end
            S_INT_WAIT2: begin
                {w_freeze_pc, w_freeze_cu, w_busy} = 3'b111;
                state_d = S_PUSH_PC1;
            end
            S_PUSH_PC1: begin
                {w_freeze_pc, w_freeze_cu, w_busy} = 3'b111;
                {w_mem_we, w_stack} = 2'b11;
                w_mem_data_sel = 2'b01;
                state_d = S_PUSH_PC2;
            end
            S_PUSH_PC2: begin
                {w_freeze_pc, w_freeze_cu, w_busy} = 3'b111;
                {w_mem_we, w_stack} = 2'b11;
                w_mem_data_sel = 2'b10;
                state_d = (src_q == c_SRC_INT) ? S_PUSH_CCR : S_LOAD_PC;
            end
            S_PUSH_CCR: begin
                {w_freeze_pc, w_freeze_cu, w_busy} = 3'b111;
                {w_mem_we, w_stack} = 2'b11;
                w_mem_data_sel = 2'b11;
                state_d = S_LOAD_PC;
            end
            S_POP_CCR: begin
                {w_freeze_pc, w_freeze_cu, w_busy} = 3'b111;
                {w_mem_re, w_stack} = 2'b11;
                w_pop_sel = 2'b11;
                state_d = S_POP_PC2;
            end
            S_POP_PC2: begin
                {w_freeze_pc, w_freeze_cu, w_busy} = 3'b111;
                {w_mem_re, w_stack} = 2'b11;
                w_pop_sel = 2'b10;
                state_d = S_POP_PC1;
            end
            S_POP_PC1: begin
                {w_freeze_pc, w_freeze_cu, w_busy} = 3'b111;
                {w_mem_re, w_stack} = 2'b11;
                w_pop_sel = 2'b01;
                state_d = S_LOAD_PC;
            end
            S_LOAD_PC: begin
                {w_freeze_cu, w_busy} = 2'b11;
                w_pc_sel = src_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mem_we       = w_mem_we;
    assign bus.mem_re       = w_mem_re;
    assign bus.stack        = w_stack;
    assign bus.mem_data_sel = w_mem_data_sel;
    assign bus.pop_sel      = w_pop_sel;
    assign bus.pc_sel       = w_pc_sel;
    assign bus.freeze_pc    = w_freeze_pc;
    assign bus.freeze_cu    = w_freeze_cu;
    assign bus.busy         = w_busy;
    assign bus.int_ack      = w_int_ack;

endmodule

`default_nettype wire

// File: tb/tb_stack_op_sequencer.sv
// ============================================================================
// Module      : tb_stack_op_sequencer
// Description : Directed self-checking bench for stack_op_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_op_sequencer;

    localparam logic [4:0] c_OP_CALL = 5'b11000;
    localparam logic [4:0] c_OP_RET  = 5'b11001;
    localparam logic [4:0] c_OP_RTI  = 5'b11010;
    localparam logic [4:0] c_OP_ADD  = 5'b00001;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    stack_op_sequencer_if sif ();

    stack_op_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector: {we, re, stack, data_sel, pop_sel, pc_sel, frz_pc, frz_cu, busy, ack}
    function automatic logic [12:0] ov(input logic we, input logic re, input logic stk,
                                       input logic [1:0] ds, input logic [1:0] ps,
                                       input logic [1:0] pc, input logic fpc,
                                       input logic fcu, input logic bsy, input logic ack);
        return {we, re, stk, ds, ps, pc, fpc, fcu, bsy, ack};
    endfunction

    logic [12:0] e_idle, e_ack, e_wait, e_p1, e_p2, e_pccr;
    logic [12:0] e_popccr, e_pop2, e_pop1, e_ld_call, e_ld_pop, e_ld_int;

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        #1;
        obs = {sif.mem_we, sif.mem_re, sif.stack, sif.mem_data_sel, sif.pop_sel,
               sif.pc_sel, sif.freeze_pc, sif.freeze_cu, sif.busy, sif.int_ack};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [12:0] exp);
        chk(tag, exp);
        @(posedge clk);
        #2;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        e_idle    = ov(0,0,0,2'b00,2'b00,2'b00,0,0,0,0);
        e_ack     = ov(0,0,0,2'b00,2'b00,2'b00,0,0,0,1);
        e_wait    = ov(0,0,0,2'b00,2'b00,2'b00,1,1,1,0);
        e_p1      = ov(1,0,1,2'b01,2'b00,2'b00,1,1,1,0);
        e_p2      = ov(1,0,1,2'b10,2'b00,2'b00,1,1,1,0);
        e_pccr    = ov(1,0,1,2'b11,2'b00,2'b00,1,1,1,0);
        e_popccr  = ov(0,1,1,2'b00,2'b11,2'b00,1,1,1,0);
        e_pop2    = ov(0,1,1,2'b00,2'b10,2'b00,1,1,1,0);
        e_pop1    = ov(0,1,1,2'b00,2'b01,2'b00,1,1,1,0);
        e_ld_call = ov(0,0,0,2'b00,2'b00,2'b01,0,1,1,0);
        e_ld_pop  = ov(0,0,0,2'b00,2'b00,2'b10,0,1,1,0);
        e_ld_int  = ov(0,0,0,2'b00,2'b00,2'b11,0,1,1,0);

        rst          = 1'b0;
        sif.opcode   = 5'b00000;
        sif.op_valid = 1'b0;
        sif.int_req  = 1'b0;
        sif.ldm      = 1'b0;
        sif.load_use = 1'b0;
        #1 rst = 1'b1;
        chk("reset_async", e_idle);
        repeat (2) @(posedge clk);
        #2;
        chk("reset_held", e_idle);
        rst = 1'b0;
        step("idle_after_reset", e_idle);

        // CALL; a RET presented mid-sequence must be ignored
        sif.op_valid = 1'b1; sif.opcode = c_OP_CALL;
        step("call_decode", e_idle);
        sif.opcode = c_OP_RET;
        step("call_push_pc1", e_p1);
        sif.op_valid = 1'b0;
        step("call_push_pc2", e_p2);
        step("call_load_pc", e_ld_call);
        step("call_done", e_idle);

        // RET
        sif.op_valid = 1'b1; sif.opcode = c_OP_RET;
        step("ret_decode", e_idle);
        sif.op_valid = 1'b0;
        step("ret_pop_pc2", e_pop2);
        step("ret_pop_pc1", e_pop1);
        step("ret_load_pc", e_ld_pop);
        step("ret_done", e_idle);

        // RTI
        sif.op_valid = 1'b1; sif.opcode = c_OP_RTI;
        step("rti_decode", e_idle);
        sif.op_valid = 1'b0;
        step("rti_pop_ccr", e_popccr);
        step("rti_pop_pc2", e_pop2);
        step("rti_pop_pc1", e_pop1);
        step("rti_load_pc", e_ld_pop);
        step("rti_done", e_idle);

        // Ordinary opcode leaves the sequencer idle
        sif.op_valid = 1'b1; sif.opcode = c_OP_ADD;
        step("other_op_decode", e_idle);
        sif.op_valid = 1'b0;
        step("other_op_stays_idle", e_idle);

        // Interrupt pulse, no load hazard
        sif.int_req = 1'b1;
        step("int_edge", e_idle);
        sif.int_req = 1'b0;
        step("int_ack", e_ack);
        step("int_wait", e_wait);
        step("int_push_pc1", e_p1);
        step("int_push_pc2", e_p2);
        step("int_push_ccr", e_pccr);
        step("int_load_pc", e_ld_int);
        step("int_done", e_idle);

        // Interrupt with load-use stall during INT_WAIT
        sif.int_req = 1'b1;
        step("lu_edge", e_idle);
        sif.int_req = 1'b0;
        step("lu_ack", e_ack);
        sif.load_use = 1'b1;
        step("lu_int_wait", e_wait);
        sif.load_use = 1'b0;
        step("lu_int_wait2", e_wait);
        step("lu_push_pc1", e_p1);
        step("lu_push_pc2", e_p2);
        step("lu_push_ccr", e_pccr);
        step("lu_load_pc", e_ld_int);
        step("lu_done", e_idle);

        // Interrupt edge coinciding with RET decode
        sif.op_valid = 1'b1; sif.opcode = c_OP_RET; sif.int_req = 1'b1;
        step("ret_int_decode", e_idle);
        sif.op_valid = 1'b0; sif.int_req = 1'b0;
        step("ret_int_pop_pc2", e_pop2);
        step("ret_int_pop_pc1", e_pop1);
        step("ret_int_load_pc", e_ld_pop);
        step("ret_int_ack", e_ack);
        step("ret_int_wait", e_wait);
        step("ret_int_push_pc1", e_p1);
        step("ret_int_push_pc2", e_p2);
        step("ret_int_push_ccr", e_pccr);
        step("ret_int_load_pc2", e_ld_int);
        step("ret_int_done", e_idle);

        // Pending interrupt while CALL decoded: CALL wins, interrupt follows
        sif.int_req = 1'b1;
        step("pend_edge", e_idle);
        sif.int_req = 1'b0; sif.op_valid = 1'b1; sif.opcode = c_OP_CALL;
        step("pend_call_decode", e_idle);
        sif.op_valid = 1'b0;
        step("pend_push_pc1", e_p1);
        step("pend_push_pc2", e_p2);
        step("pend_load_pc", e_ld_call);
        step("pend_ack", e_ack);
        step("pend_wait", e_wait);
        step("pend_push_pc1b", e_p1);
        step("pend_push_pc2b", e_p2);
        step("pend_push_ccr", e_pccr);
        step("pend_load_pcb", e_ld_int);
        step("pend_done", e_idle);

        // Reset in PUSH_PC2 with an interrupt latched during the sequence
        sif.op_valid = 1'b1; sif.opcode = c_OP_CALL;
        step("rst_call_decode", e_idle);
        sif.op_valid = 1'b0; sif.int_req = 1'b1;
        step("rst_push_pc1", e_p1);
        sif.int_req = 1'b0;
        chk("rst_push_pc2", e_p2);
        rst = 1'b1;
        chk("rst_mid_outputs", e_idle);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step("rst_release_idle", e_idle);
        step("rst_no_pending", e_idle);
        step("rst_still_idle", e_idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stack_op_sequencer.md
STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

Interface
REQ-001 SHALL have: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: opcode  in  5  decode-stage opcode (CALL=11000, RET=11001, RTI=11010).
REQ-004 SHALL have: op_valid  in  1  opcode is a live decode-stage instruction.
REQ-005 SHALL have: int_req  in  1  external interrupt request line.
REQ-006 SHALL have: ldm, load_use  in  1 each  LDM in flight / load-use stall active.
REQ-007 SHALL have: mem_we, mem_re, stack  out  1 each  data-memory write, read, SP-addressed access.
REQ-008 SHALL have: mem_data_sel  out  2  push source: 00 ALU, 01 PC[31:16], 10 PC[15:0], 11 CCR.
REQ-009 SHALL have: pop_sel  out  2  pop destination: 00 none, 01 PC high, 10 PC low, 11 CCR.
REQ-010 SHALL have: pc_sel  out  2  PC source: 00 PC+1, 01 call target, 10 popped PC, 11 interrupt vector.
REQ-011 SHALL have: freeze_pc, freeze_cu, busy, int_ack  out  1 each.

Function
REQ-012 SHALL implement one FSM, states: IDLE, INT_WAIT, INT_WAIT2, PUSH_PC1, PUSH_PC2, PUSH_CCR, POP_CCR, POP_PC2, POP_PC1, LOAD_PC; 4-bit encoding.
REQ-013 SHALL register int_req (int_req_d) and set int_pending on rising edge (int_req & ~int_req_d).
REQ-014 SHALL clear int_pending on IDLE->INT_WAIT; set wins if edge and clear coincide.
REQ-015 In IDLE with op_valid & CALL: next PUSH_PC1 -> PUSH_PC2 -> LOAD_PC -> IDLE.
REQ-016 In IDLE with op_valid & RET: next POP_PC2 -> POP_PC1 -> LOAD_PC -> IDLE.
REQ-017 In IDLE with op_valid & RTI: next POP_CCR -> POP_PC2 -> POP_PC1 -> LOAD_PC -> IDLE.
REQ-018 In IDLE with int_pending and no CALL/RET/RTI decoded: next INT_WAIT; int_ack=1 that cycle only.
REQ-019 Simultaneous CALL/RET/RTI and int_pending in IDLE: instruction sequence first; interrupt taken on next IDLE cycle.
REQ-020 INT_WAIT: ldm|load_use -> INT_WAIT2, else PUSH_PC1; INT_WAIT2 -> PUSH_PC1 unconditionally.
REQ-021 Interrupt path: PUSH_PC1 -> PUSH_PC2 -> PUSH_CCR -> LOAD_PC -> IDLE.
REQ-022 PUSH_PC1/PUSH_PC2/PUSH_CCR: mem_we=1, stack=1, mem_data_sel=01/10/11 respectively.
REQ-023 POP_CCR/POP_PC2/POP_PC1: mem_re=1, stack=1, pop_sel=11/10/01 respectively.
REQ-024 LOAD_PC: pc_sel=01 after CALL, 10 after RET/RTI, 11 after interrupt; source held in 2-bit register captured on IDLE exit.
REQ-025 pc_sel SHALL be 00 in every state other than LOAD_PC.
REQ-026 freeze_cu=1 in every state except IDLE; freeze_pc=1 in every state except IDLE and LOAD_PC.
REQ-027 busy=1 whenever state != IDLE.
REQ-028 Outputs SHALL be Moore (state-decoded) except int_ack; no output may be X or latched.
REQ-029 opcode/op_valid SHALL be ignored outside IDLE; non-CALL/RET/RTI opcodes SHALL leave FSM in IDLE.
REQ-030 Busy cycles: CALL 3, RET 3, RTI 4, interrupt 5 (6 with ldm|load_use in INT_WAIT).
REQ-031 Unused state encodings SHALL return to IDLE next cycle with all outputs 0.

Reset
REQ-032 rst SHALL force IDLE, int_pending=0, int_req_d=0, source register=00 immediately, without waiting for clk.
REQ-033 During reset all outputs SHALL be 0; reset mid-sequence abandons the sequence with no further memory access.

Verification
REQ-034 CALL op_valid in IDLE -> mem_we 2 cycles (sel 01,10), then pc_sel=01 one cycle, freeze_cu 3 cycles, IDLE.
REQ-035 RTI -> mem_re 3 cycles with pop_sel 11,10,01, then pc_sel=10, busy exactly 4 cycles.
REQ-036 int_req pulse, ldm=0, load_use=0 -> int_ack one cycle, 1 wait, pushes 01,10,11, pc_sel=11, busy 5 cycles.
REQ-037 int_req edge same cycle as RET decode -> RET sequence completes (3 cycles), then interrupt sequence starts next cycle.
REQ-038 load_use=1 during INT_WAIT -> INT_WAIT2 inserted, busy 6 cycles, push order unchanged.
REQ-039 rst asserted in PUSH_PC2 -> all outputs 0 same cycle, IDLE after release, no pending interrupt.
